// File: rtl/vga_frame_checker.sv
// vga_frame_checker: passive VGA sink that recovers x/y from sync edges,
// checks mode timing, and signs each clean active frame with a 16-bit MISR.
module vga_frame_checker #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active,
  output logic [2:0]  pix_rgb,
  output logic        locked,
  output logic [15:0] frame_sig,
  output logic        sig_valid,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] HT_M1  = 10'(H_TOTAL - 1);
  localparam logic [9:0] VT_M1  = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_POS = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] VS_POS = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] HS_M1  = 10'(H_ACTIVE + H_FRONT - 1);
  localparam logic [9:0] VS_M1  = 10'(V_ACTIVE + V_FRONT - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] HA_M1  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] VA_M1  = 10'(V_ACTIVE - 1);
  localparam logic       POL    = 1'(SYNC_ACTIVE_LOW != 0);
  localparam logic [7:0] LOCK_N = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    SYNCING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [7:0]  good, good_next;
  logic        hs_r, vs_r, hs_prev, vs_prev;
  logic [2:0]  rgb_r;
  logic        hs_edge, vs_edge;
  logic [9:0]  x_next, y_next;
  logic        h_mis, v_mis, mis;
  logic [15:0] sig, seed, sig_step;
  logic        frame_start, last_pix, frame_clean, emit;

  assign hs_edge = hs_r & ~hs_prev;
  assign vs_edge = vs_r & ~vs_prev;

  assign h_mis = hs_edge ^ (x == HS_M1);
  assign v_mis = vs_edge ^ ((x == HT_M1) && (y == VS_M1));
  assign mis   = (state != SEARCH) & (h_mis | v_mis);

  assign frame_start = (x == 10'd0) && (y == 10'd0);
  assign last_pix    = active && (x == HA_M1) && (y == VA_M1);
  assign seed        = frame_start ? 16'hFFFF : sig;
  assign sig_step    = {seed[14:0], 1'b0}
                     ^ (seed[15] ? 16'h1021 : 16'h0000)
                     ^ {13'b0, pix_rgb};
  assign emit        = last_pix && frame_clean && !mis;

  // Stage 1: register inputs with syncs normalised to active-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r    <= 1'b0;
      vs_r    <= 1'b0;
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      rgb_r   <= 3'd0;
    end else begin
      hs_r    <= hsync ^ POL;
      vs_r    <= vsync ^ POL;
      hs_prev <= hs_r;
      vs_prev <= vs_r;
      rgb_r   <= rgb;
    end
  end

  // Next x/y: free-run with wrap, reloaded to sync start on sync edges.
  always_comb begin
    x_next = (x == HT_M1) ? 10'd0 : x + 10'd1;
    if (hs_edge) x_next = HS_POS;
    y_next = y;
    if ((x == HT_M1) && !hs_edge)
      y_next = (y == VT_M1) ? 10'd0 : y + 10'd1;
    if (vs_edge) y_next = VS_POS;
  end

  // Stage 2: recovered coordinates aligned with the delayed pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      x       <= 10'd0;
      y       <= 10'd0;
      pix_rgb <= 3'd0;
      active  <= 1'b0;
    end else begin
      x       <= x_next;
      y       <= y_next;
      pix_rgb <= rgb_r;
      active  <= (x_next < HA) && (y_next < VA);
    end
  end

  // Lock FSM next state: count clean vsyncs until enough to lock.
  always_comb begin
    state_next = state;
    good_next  = good;
    unique case (state)
      SEARCH: begin
        if (vs_edge) begin
          state_next = SYNCING;
          good_next  = 8'd0;
        end
      end
      SYNCING: begin
        if (mis) begin
          good_next = 8'd0;
        end else if (vs_edge) begin
          good_next = good + 8'd1;
          if (good + 8'd1 >= LOCK_N) state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (mis) state_next = SEARCH;
      end
      default: state_next = SEARCH;
    endcase
  end

  // Lock FSM registers, lock flag and saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      good      <= 8'd0;
      locked    <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state  <= state_next;
      good   <= good_next;
      locked <= (state_next == LOCKED);
      if ((state == LOCKED) && mis && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  // MISR over active pixels; publish it at the end of a clean frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig         <= 16'hFFFF;
      frame_clean <= 1'b0;
      frame_sig   <= 16'd0;
      sig_valid   <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      if (active) sig <= sig_step;
      if (mis) frame_clean <= 1'b0;
      else if (frame_start) frame_clean <= (state == LOCKED);
      sig_valid <= emit;
      if (emit) begin
        frame_sig   <= sig_step;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_checker.sv
// tb_vga_frame_checker: directed bench driving a tiny video mode with
// sync glitches, pixel flips and mid-frame reset against a MISR model.
module tb_vga_frame_checker;

  localparam int HA  = 8;
  localparam int HF  = 2;
  localparam int HSY = 3;
  localparam int HBK = 3;
  localparam int VA  = 6;
  localparam int VF  = 1;
  localparam int VSY = 2;
  localparam int VBK = 2;
  localparam int HT  = HA + HF + HSY + HBK;
  localparam int VT  = VA + VF + VSY + VBK;
  localparam int HS0 = HA + HF;
  localparam int VS0 = VA + VF;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        active;
  logic [2:0]  pix_rgb;
  logic        locked;
  logic [15:0] frame_sig;
  logic        sig_valid;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  int hp, vp, hp_d1, vp_d1;
  logic [2:0] rgb_d1;
  int pat;
  bit hg, vg, fl;
  int xy_bad, act_cnt, sv_cnt, rise_cnt, fall_cnt, fidx;
  logic [19:0] rise_pos, fall_pos;
  logic [15:0] sig_got;
  logic lk_prev;

  vga_frame_checker #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HBK),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VBK),
    .SYNC_ACTIVE_LOW(1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hsync(hsync),
    .vsync(vsync),
    .rgb(rgb),
    .x(x),
    .y(y),
    .active(active),
    .pix_rgb(pix_rgb),
    .locked(locked),
    .frame_sig(frame_sig),
    .sig_valid(sig_valid),
    .frame_count(frame_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] pix(input int p, input int xx,
                                     input int yy, input bit f);
    logic [2:0] c;
    c = (p == 0) ? 3'd0 : 3'(xx * 3 + yy * 5 + 1);
    if (f && xx == 3 && yy == 2) c = ~c;
    return c;
  endfunction

  function automatic logic [15:0] misr(input int p, input bit f);
    logic [15:0] s;
    s = 16'hFFFF;
    for (int yy = 0; yy < VA; yy++)
      for (int xx = 0; xx < HA; xx++)
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)
          ^ {13'b0, pix(p, xx, yy, f)};
    return s;
  endfunction

  function automatic logic [19:0] pos(input int yy, input int xx);
    return {10'(yy), 10'(xx)};
  endfunction

  task automatic step();
    logic hs_a, vs_a;
    logic [2:0] c;
    hs_a = (hp >= HS0) && (hp < HS0 + HSY);
    if (hg && vp == 3) hs_a = (hp >= HS0 + 1) && (hp < HS0 + 1 + HSY);
    vs_a = (vp >= VS0) && (vp < VS0 + VSY) && !vg;
    c = (hp < HA && vp < VA) ? pix(pat, hp, vp, fl) : 3'd0;
    hsync = ~hs_a;
    vsync = ~vs_a;
    rgb   = c;
    @(posedge clk);
    #1;
    if (locked) begin
      if (x !== 10'(hp_d1) || y !== 10'(vp_d1) || pix_rgb !== rgb_d1 ||
          active !== (hp_d1 < HA && vp_d1 < VA))
        xy_bad++;
    end
    if (active) act_cnt++;
    if (sig_valid) begin
      sv_cnt++;
      sig_got = frame_sig;
    end
    if (locked && !lk_prev) begin
      rise_cnt++;
      rise_pos = pos(vp_d1, hp_d1);
    end
    if (!locked && lk_prev) begin
      fall_cnt++;
      fall_pos = pos(vp_d1, hp_d1);
    end
    lk_prev = locked;
    hp_d1 = hp;
    vp_d1 = vp;
    rgb_d1 = c;
    if (hp == HT - 1) begin
      hp = 0;
      vp = (vp == VT - 1) ? 0 : vp + 1;
    end else begin
      hp = hp + 1;
    end
  endtask

  task automatic run_frame(input int p, input bit h, input bit v,
                           input bit f);
    pat = p; hg = h; vg = v; fl = f;
    xy_bad = 0; act_cnt = 0; sv_cnt = 0;
    rise_cnt = 0; fall_cnt = 0;
    rise_pos = '0; fall_pos = '0;
    sig_got = '0;
    for (int i = 0; i < HT * VT; i++) step();
    fidx++;
  endtask

  task automatic reset_vals(input string ph);
    check({ph, "_x"}, 32'(x), 0);
    check({ph, "_y"}, 32'(y), 0);
    check({ph, "_active"}, 32'(active), 0);
    check({ph, "_pix"}, 32'(pix_rgb), 0);
    check({ph, "_locked"}, 32'(locked), 0);
    check({ph, "_fsig"}, 32'(frame_sig), 0);
    check({ph, "_sigv"}, 32'(sig_valid), 0);
    check({ph, "_fcnt"}, 32'(frame_count), 0);
    check({ph, "_ecnt"}, 32'(err_count), 0);
  endtask

  task automatic expect_sig(input int p, input bit f, input int fc);
    string t;
    t = $sformatf("f%0d", fidx - 1);
    check({t, "_sv_cnt"}, 32'(sv_cnt), 1);
    check({t, "_sig"}, 32'(sig_got), 32'(misr(p, f)));
    check({t, "_fcnt"}, 32'(frame_count), 32'(fc));
    check({t, "_act"}, 32'(act_cnt), HA * VA);
    check({t, "_align"}, 32'(xy_bad), 0);
  endtask

  task automatic expect_relock(input string t);
    check({t, "_rise"}, 32'(rise_cnt), 1);
    check({t, "_rise_pos"}, 32'(rise_pos), 32'(pos(VS0, 0)));
    check({t, "_locked"}, 32'(locked), 1);
    check({t, "_sv_none"}, 32'(sv_cnt), 0);
  endtask

  task automatic lock_seq(input string t, input int fc);
    run_frame(0, 0, 0, 0);
    check({t, "_nolock0"}, 32'(locked), 0);
    run_frame(0, 0, 0, 0);
    check({t, "_nolock1"}, 32'(locked), 0);
    run_frame(0, 0, 0, 0);
    expect_relock({t, "_lock"});
    run_frame(0, 0, 0, 0);
    expect_sig(0, 0, fc);
  endtask

  initial begin
    reset = 1'b1;
    hsync = 1'b1;
    vsync = 1'b1;
    rgb = 3'd0;
    hp = 0; vp = 0; hp_d1 = 0; vp_d1 = 0;
    rgb_d1 = 3'd0; lk_prev = 1'b0; fidx = 0;
    pat = 0; hg = 0; vg = 0; fl = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_vals("rst");
    reset = 1'b0;

    lock_seq("s1", 1);
    run_frame(0, 0, 0, 0);
    expect_sig(0, 0, 2);

    run_frame(1, 0, 0, 0);
    expect_sig(1, 0, 3);
    run_frame(1, 0, 0, 0);
    expect_sig(1, 0, 4);
    run_frame(1, 0, 0, 1);
    expect_sig(1, 1, 5);
    check("flip_differs", 32'(sig_got != misr(1, 0)), 1);
    run_frame(1, 0, 0, 0);
    expect_sig(1, 0, 6);

    run_frame(1, 1, 0, 0);
    check("hglitch_fall", 32'(fall_cnt), 1);
    check("hglitch_pos", 32'(fall_pos), 32'(pos(3, HS0)));
    check("hglitch_err", 32'(err_count), 1);
    check("hglitch_sv", 32'(sv_cnt), 0);
    check("hglitch_unlk", 32'(locked), 0);
    run_frame(1, 0, 0, 0);
    check("hrelock_wait", 32'(locked), 0);
    run_frame(1, 0, 0, 0);
    expect_relock("hrelock");
    run_frame(1, 0, 0, 0);
    expect_sig(1, 0, 7);

    run_frame(1, 0, 1, 0);
    expect_sig(1, 0, 8);
    check("vglitch_fall", 32'(fall_cnt), 1);
    check("vglitch_pos", 32'(fall_pos), 32'(pos(VS0, 0)));
    check("vglitch_err", 32'(err_count), 2);
    run_frame(0, 0, 0, 0);
    check("vrelock_w0", 32'(locked), 0);
    run_frame(0, 0, 0, 0);
    check("vrelock_w1", 32'(locked), 0);
    run_frame(0, 0, 0, 0);
    expect_relock("vrelock");
    run_frame(0, 0, 0, 0);
    expect_sig(0, 0, 9);

    for (int i = 0; i < 3 * HT; i++) step();
    check("midrst_line", 32'(vp), 3);
    reset = 1'b1;
    step();
    reset_vals("midrst");
    reset = 1'b0;
    hp = 0; vp = 0; lk_prev = 1'b0; fidx = 0;
    lock_seq("s6", 1);
    check("s6_err", 32'(err_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
